stopwatch_control: RTL and testbench

Run-control front end for the stopwatch. Debounces the two user push-buttons (start/stop, lap/reset) and runs the run/stop/lap state machine. Generates the 1 ms count-enable tick and clear pulse that drive the BCD counter, plus the freeze level that holds the displayed time during a lap. Sits directly upstream of the stopwatch counter and display path.

---
 rtl/stopwatch_control.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_control.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_control.sv
// stopwatch_control: button conditioning plus run/stop/lap control for the
// stopwatch. Produces the count-enable tick, the clear pulse and the lap
// freeze level for the downstream BCD counter and display.

// One button path: 2-FF synchronizer, debouncer, rising-edge detector.
module stopwatch_control_btn #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_prev_q, level_prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Debounce: the level flips once the synchronized input has disagreed
    // with it for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_comb begin
        sync1_d      = raw_in;
        sync2_d      = sync1_q;
        level_d      = level_q;
        level_prev_d = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Button path registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    // A press is a debounced 0->1 transition; releases are ignored.
    assign press = level_q & ~level_prev_q;
endmodule

module stopwatch_control #(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int TICK_HZ         = 1000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clkIn,
    input  logic       rstIn,
    input  logic       startStopBtnIn,
    input  logic       lapResetBtnIn,
    output logic       tickOut,
    output logic       clearOut,
    output logic       freezeOut,
    output logic [1:0] stateOut
);
    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_e;

    logic             ss_press, lr_press;
    state_e           state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             clear_q, clear_d;
    logic             freeze_q, freeze_d;
    logic             cur_counting, nxt_counting;

    stopwatch_control_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss_btn (
        .clk    (clkIn),
        .rst_n  (rstIn),
        .raw_in (startStopBtnIn),
        .press  (ss_press)
    );

    stopwatch_control_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr_btn (
        .clk    (clkIn),
        .rst_n  (rstIn),
        .raw_in (lapResetBtnIn),
        .press  (lr_press)
    );

    // Next state; start/stop takes priority over lap/reset in the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (ss_press) state_d = RUN;
            RUN: begin
                if (ss_press)      state_d = STOP;
                else if (lr_press) state_d = LAP;
            end
            LAP: begin
                if (ss_press)      state_d = STOP;
                else if (lr_press) state_d = RUN;
            end
            STOP: begin
                if (ss_press)      state_d = RUN;
                else if (lr_press) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Prescaler advances only on edges that stay within RUN/LAP, so the
    // first tick lands TICK_DIV cycles after entering RUN and a tick can
    // never coincide with STOP or IDLE on the outputs.
    always_comb begin
        cur_counting = (state_q == RUN) || (state_q == LAP);
        nxt_counting = (state_d == RUN) || (state_d == LAP);
        presc_d      = presc_q;
        tick_d       = 1'b0;
        if (state_d == IDLE) begin
            presc_d = '0;
        end else if (cur_counting && nxt_counting) begin
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        clear_d  = (state_q == STOP) && (state_d == IDLE);
        freeze_d = (state_d == LAP);
    end

    // Control registers; all outputs come straight from flops.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            state_q  <= IDLE;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            clear_q  <= 1'b0;
            freeze_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            clear_q  <= clear_d;
            freeze_q <= freeze_d;
        end
    end

    assign tickOut   = tick_q;
    assign clearOut  = clear_q;
    assign freezeOut = freeze_q;
    assign stateOut  = state_q;
endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed scenarios plus random button
// activity, all outputs compared every cycle against a behavioural model.
module tb_stopwatch_control;
    localparam int CLK_HZ = 1000;
    localparam int TK_HZ  = 100;
    localparam int D      = 4;
    localparam int DIV    = CLK_HZ / TK_HZ;

    logic       clkIn = 1'b0;
    logic       rstIn = 1'b0;
    logic       startStopBtnIn = 1'b1;
    logic       lapResetBtnIn = 1'b1;
    logic       tickOut, clearOut, freezeOut;
    logic [1:0] stateOut;

    int errors = 0;
    int checks = 0;

    stopwatch_control #(
        .CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(TK_HZ), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clkIn          (clkIn),
        .rstIn          (rstIn),
        .startStopBtnIn (startStopBtnIn),
        .lapResetBtnIn  (lapResetBtnIn),
        .tickOut        (tickOut),
        .clearOut       (clearOut),
        .freezeOut      (freezeOut),
        .stateOut       (stateOut)
    );

    always #5 clkIn = ~clkIn;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // raw_h[b][k]: raw samples at previous edges, index D = most recent.
    // A debounced level flips when the D samples that reached the debouncer
    // (two edges of synchronizer delay) all disagree with it.
    bit raw_h [2][D+1];
    bit lv [2];
    bit lvp [2];
    bit prs [2];
    bit raw_now [2];
    bit all_diff;
    int m_state, m_nxt, m_cnt;
    bit m_tick, m_clear, m_freeze, m_valid = 0;

    function automatic bit counting(input int s);
        return (s == 1) || (s == 3);
    endfunction

    always @(posedge clkIn) begin
        if (!rstIn) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k <= D; k++) raw_h[b][k] = 0;
                lv[b] = 0; lvp[b] = 0;
            end
            m_state = 0; m_cnt = 0;
            m_tick = 0; m_clear = 0; m_freeze = 0;
            m_valid = 1;
        end else begin
            raw_now[0] = startStopBtnIn;
            raw_now[1] = lapResetBtnIn;
            for (int b = 0; b < 2; b++) begin
                prs[b] = lv[b] && !lvp[b];
                all_diff = 1;
                for (int k = 0; k < D; k++) if (raw_h[b][k] == lv[b]) all_diff = 0;
                lvp[b] = lv[b];
                if (all_diff) lv[b] = !lv[b];
                for (int k = 0; k < D; k++) raw_h[b][k] = raw_h[b][k+1];
                raw_h[b][D] = raw_now[b];
            end
            m_nxt = m_state;
            if (prs[0]) begin
                if (m_state == 1 || m_state == 3) m_nxt = 2;
                else m_nxt = 1;
            end else if (prs[1]) begin
                case (m_state)
                    1: m_nxt = 3;
                    3: m_nxt = 1;
                    2: m_nxt = 0;
                    default: m_nxt = m_state;
                endcase
            end
            m_clear = (m_state == 2) && (m_nxt == 0);
            m_tick  = 0;
            if (m_nxt == 0) m_cnt = 0;
            else if (counting(m_state) && counting(m_nxt)) begin
                m_cnt++;
                if (m_cnt == DIV) begin m_cnt = 0; m_tick = 1; end
            end
            m_freeze = (m_nxt == 3);
            m_state  = m_nxt;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clkIn) begin
        if (m_valid) begin
            chk("state",  int'(stateOut),  m_state);
            chk("tick",   int'(tickOut),   int'(m_tick));
            chk("clear",  int'(clearOut),  int'(m_clear));
            chk("freeze", int'(freezeOut), int'(m_freeze));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit ss, input bit lr);
        @(posedge clkIn); #1;
        startStopBtnIn = ss;
        lapResetBtnIn  = lr;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clkIn);
    endtask

    task automatic press(input bit ss, input bit lr);
        drive(ss, lr); wait_cyc(8);
        drive(0, 0);   wait_cyc(8);
    endtask

    initial begin
        int hold;
        bit bounce [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

        // Reset with both buttons held: outputs zero, then ss wins on exit.
        wait_cyc(3);
        @(negedge clkIn);
        chk("rst_state", int'(stateOut), 0);
        chk("rst_tick",  int'(tickOut), 0);
        chk("rst_clear", int'(clearOut), 0);
        chk("rst_freeze", int'(freezeOut), 0);
        @(posedge clkIn); #1; rstIn = 1'b1;
        wait_cyc(10);
        @(negedge clkIn);
        chk("rst_exit_run", int'(stateOut), 1);
        drive(0, 0); wait_cyc(8);
        press(1, 0);
        press(0, 1);
        @(negedge clkIn);
        chk("back_idle", int'(stateOut), 0);

        // Clean start: state at t+7, first tick at t+17, then every 10.
        drive(1, 0);
        wait_cyc(6);
        @(negedge clkIn); chk("start_t6", int'(stateOut), 0);
        @(posedge clkIn);
        @(negedge clkIn); chk("start_t7", int'(stateOut), 1);
        wait_cyc(9);
        @(negedge clkIn); chk("tick_t16", int'(tickOut), 0);
        @(posedge clkIn);
        @(negedge clkIn); chk("tick_t17", int'(tickOut), 1);
        wait_cyc(10);
        @(negedge clkIn); chk("tick_t27", int'(tickOut), 1);
        drive(0, 0); wait_cyc(8);

        // Bounce rejection from IDLE.
        press(1, 0);
        press(0, 1);
        for (int i = 0; i < 8; i++) drive(bounce[i], 0);
        wait_cyc(8);
        @(negedge clkIn); chk("bounce_idle", int'(stateOut), 0);
        drive(1, 0); wait_cyc(8);
        @(negedge clkIn); chk("bounce_run", int'(stateOut), 1);
        drive(0, 0); wait_cyc(8);

        // Lap enter/exit.
        press(0, 1);
        @(negedge clkIn);
        chk("lap_state", int'(stateOut), 3);
        chk("lap_freeze", int'(freezeOut), 1);
        wait_cyc(25);
        press(0, 1);
        @(negedge clkIn);
        chk("unlap_state", int'(stateOut), 1);
        chk("unlap_freeze", int'(freezeOut), 0);

        // Stop, resume, stop, clear.
        wait_cyc(25);
        press(1, 0);
        @(negedge clkIn); chk("stop_state", int'(stateOut), 2);
        wait_cyc(20);
        press(1, 0);
        @(negedge clkIn); chk("resume_state", int'(stateOut), 1);
        wait_cyc(10);
        press(1, 0);
        press(0, 1);
        @(negedge clkIn); chk("clear_idle", int'(stateOut), 0);

        // Simultaneous presses in LAP and RUN: start/stop wins.
        press(1, 0);
        press(0, 1);
        press(1, 1);
        @(negedge clkIn);
        chk("simul_lap_state", int'(stateOut), 2);
        chk("simul_lap_freeze", int'(freezeOut), 0);
        press(1, 0);
        wait_cyc(13);
        press(1, 1);
        @(negedge clkIn);
        chk("simul_run_state", int'(stateOut), 2);

        // Random button activity with occasional resets.
        for (int seg = 0; seg < 400; seg++) begin
            hold = $urandom_range(1, 12);
            if ($urandom_range(0, 60) == 0) begin
                @(posedge clkIn); #1; rstIn = 1'b0;
                wait_cyc($urandom_range(1, 3));
                @(posedge clkIn); #1; rstIn = 1'b1;
            end
            drive($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            wait_cyc(hold);
        end
        drive(0, 0);
        wait_cyc(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
